// File: rtl/csc_spad_pkg.sv
// rtl/csc_spad_pkg.sv - shared types, constants and helpers for the CSC address scratchpad
package csc_spad_pkg;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    localparam int TERM = 0;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/csc_addr_spad_bank.sv
// rtl/csc_addr_spad_bank.sv - one scratchpad bank: sync write port, combinational read port
module spad_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 12,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; a bank is only read once sealed.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/csc_addr_spad.sv
// rtl/csc_addr_spad.sv - double-buffered zero-terminated address scratchpad for the PE
module csc_addr_spad
    import csc_spad_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 12,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write_en,
    output logic              write_fin,
    output logic              overflow,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    input  logic              index_inc,
    input  logic              rewind,
    input  logic              bank_release,
    output logic              read_fin,
    output logic [1:0]        bank_full
);

    localparam logic [DATA_W-1:0] TERM_WORD = DATA_W'(TERM);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    bank_state_t       bank_state [2];
    logic              wb;
    logic              rb;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata [2];

    logic              shake;
    logic              at_last;
    logic              seal;
    logic              overrun;
    logic [DATA_W-1:0] wdata;
    logic              release_ok;
    logic              inc_ok;

    assign bank_full[0] = (bank_state[0] == BANK_FULL);
    assign bank_full[1] = (bank_state[1] == BANK_FULL);

    assign data_in_ready = !bank_full[wb];
    assign shake         = data_in_valid && data_in_ready && write_en;
    assign at_last       = (waddr == LAST_ADDR);
    // The last slot of a bank always holds a terminator, so a vector never runs off the end.
    assign overrun       = shake && (data_in != TERM_WORD) && at_last;
    assign seal          = shake && ((data_in == TERM_WORD) || at_last);
    assign wdata         = at_last ? TERM_WORD : data_in;
    assign write_fin     = seal;

    assign data_out_valid = bank_full[rb];
    assign data_out       = data_out_valid ? rdata[rb] : TERM_WORD;

    assign release_ok = bank_release && data_out_valid;
    assign inc_ok     = !release_ok && !rewind && index_inc && data_out_valid;
    assign read_fin   = inc_ok && (data_out == TERM_WORD);

    for (genvar i = 0; i < 2; i++) begin : g_bank
        localparam logic BANK_ID = 1'(i);
        spad_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clock (clock),
            .we    (shake && (wb == BANK_ID)),
            .waddr (waddr),
            .wdata (wdata),
            .raddr (raddr),
            .rdata (rdata[i])
        );
    end

    // Pointer and bank-state update; seal and release always hit different banks.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb            <= 1'b0;
            rb            <= 1'b0;
            waddr         <= '0;
            raddr         <= '0;
            overflow      <= 1'b0;
            bank_state[0] <= BANK_EMPTY;
            bank_state[1] <= BANK_EMPTY;
        end else begin
            if (shake) begin
                if (seal) begin
                    bank_state[wb] <= BANK_FULL;
                    waddr          <= '0;
                    wb             <= ~wb;
                end else begin
                    waddr <= waddr + ADDR_W'(1);
                end
            end
            if (overrun) begin
                overflow <= 1'b1;
            end
            if (release_ok) begin
                bank_state[rb] <= BANK_EMPTY;
                rb             <= ~rb;
                raddr          <= '0;
            end else if (rewind) begin
                raddr <= '0;
            end else if (inc_ok) begin
                raddr <= read_fin ? '0 : raddr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_csc_addr_spad.sv
// tb/tb_csc_addr_spad.sv - directed self-checking bench for csc_addr_spad
module tb_csc_addr_spad;

    logic       clock;
    logic       reset;
    logic       data_in_valid;
    logic       data_in_ready;
    logic [7:0] data_in;
    logic       write_en;
    logic       write_fin;
    logic       overflow;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       index_inc;
    logic       rewind;
    logic       bank_release;
    logic       read_fin;
    logic [1:0] bank_full;

    int checks = 0;
    int errors = 0;

    csc_addr_spad dut (
        .clock          (clock),
        .reset          (reset),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_in        (data_in),
        .write_en       (write_en),
        .write_fin      (write_fin),
        .overflow       (overflow),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .index_inc      (index_inc),
        .rewind         (rewind),
        .bank_release   (bank_release),
        .read_fin       (read_fin),
        .bank_full      (bank_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of stimulus starting 1 time unit after a rising edge,
    // capture the combinational pulses before the next edge, then idle the inputs.
    task automatic step(input logic wv, input logic [7:0] wd, input logic inc,
                        input logic rew, input logic rel,
                        output logic wfin, output logic rfin, output logic rdy);
        data_in_valid = wv;
        data_in       = wd;
        write_en      = wv;
        index_inc     = inc;
        rewind        = rew;
        bank_release  = rel;
        #1;
        wfin = write_fin;
        rfin = read_fin;
        rdy  = data_in_ready;
        @(posedge clock);
        #1;
        data_in_valid = 1'b0;
        data_in       = 8'd0;
        write_en      = 1'b0;
        index_inc     = 1'b0;
        rewind        = 1'b0;
        bank_release  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({data_in_ready, write_fin, overflow, data_out_valid, read_fin} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got rdy/wfin/ovf/vld/rfin=%b expected 10000",
                     {data_in_ready, write_fin, overflow, data_out_valid, read_fin});
        end
        checks++;
        if (data_out !== 8'd0 || bank_full !== 2'b00) begin
            errors++;
            $display("FAIL reset_data got data_out=%0d bank_full=%b expected 0 00", data_out, bank_full);
        end
    endtask

    task automatic test_basic();
        logic [7:0] vec [4] = '{8'd5, 8'd9, 8'd3, 8'd0};
        logic wf, rf, rdy;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vec[i], 1'b0, 1'b0, 1'b0, wf, rf, rdy);
            checks++;
            if (wf !== (i == 3)) begin
                errors++;
                $display("FAIL basic_write_fin word %0d got %b expected %b", i, wf, (i == 3));
            end
        end
        checks++;
        if (data_out_valid !== 1'b1 || data_out !== 8'd5 || bank_full !== 2'b01) begin
            errors++;
            $display("FAIL basic_sealed got vld=%b data_out=%0d bank_full=%b expected 1 5 01",
                     data_out_valid, data_out, bank_full);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_out !== vec[i]) begin
                errors++;
                $display("FAIL basic_read idx %0d got %0d expected %0d", i, data_out, vec[i]);
            end
            step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, wf, rf, rdy);
            checks++;
            if (rf !== (i == 3)) begin
                errors++;
                $display("FAIL basic_read_fin idx %0d got %b expected %b", i, rf, (i == 3));
            end
        end
        checks++;
        if (data_out !== 8'd5 || data_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_reuse got data_out=%0d vld=%b expected 5 1", data_out, data_out_valid);
        end
    endtask

    task automatic test_ping_pong();
        logic wf, rf, rdy;
        step(1'b1, 8'd7, 1'b0, 1'b0, 1'b0, wf, rf, rdy);
        step(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, wf, rf, rdy);
        checks++;
        if (bank_full !== 2'b11 || data_out !== 8'd5) begin
            errors++;
            $display("FAIL pp_both_full got bank_full=%b data_out=%0d expected 11 5", bank_full, data_out);
        end
        step(1'b1, 8'd4, 1'b0, 1'b0, 1'b0, wf, rf, rdy);
        checks++;
        if (rdy !== 1'b0 || wf !== 1'b0 || bank_full !== 2'b11) begin
            errors++;
            $display("FAIL pp_blocked got rdy=%b wfin=%b bank_full=%b expected 0 0 11", rdy, wf, bank_full);
        end
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, wf, rf, rdy);
        checks++;
        if (data_out !== 8'd7 || data_in_ready !== 1'b1 || bank_full !== 2'b10) begin
            errors++;
            $display("FAIL pp_release got data_out=%0d rdy=%b bank_full=%b expected 7 1 10",
                     data_out, data_in_ready, bank_full);
        end
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, wf, rf, rdy);
        checks++;
        if (bank_full !== 2'b00 || data_out_valid !== 1'b0 || data_out !== 8'd0) begin
            errors++;
            $display("FAIL pp_drain got bank_full=%b vld=%b data_out=%0d expected 00 0 0",
                     bank_full, data_out_valid, data_out);
        end
    endtask

    task automatic test_overflow();
        logic wf, rf, rdy;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, wf, rf, rdy);
            checks++;
            if (wf !== (i == 12)) begin
                errors++;
                $display("FAIL ovf_write_fin word %0d got %b expected %b", i, wf, (i == 12));
            end
        end
        checks++;
        if (overflow !== 1'b1 || bank_full !== 2'b01) begin
            errors++;
            $display("FAIL ovf_flag got overflow=%b bank_full=%b expected 1 01", overflow, bank_full);
        end
        for (int i = 1; i <= 12; i++) begin
            checks++;
            if (data_out !== ((i == 12) ? 8'd0 : 8'(i))) begin
                errors++;
                $display("FAIL ovf_read idx %0d got %0d expected %0d", i, data_out, (i == 12) ? 0 : i);
            end
            step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, wf, rf, rdy);
            checks++;
            if (rf !== (i == 12)) begin
                errors++;
                $display("FAIL ovf_read_fin idx %0d got %b expected %b", i, rf, (i == 12));
            end
        end
        checks++;
        if (overflow !== 1'b1 || data_out !== 8'd1) begin
            errors++;
            $display("FAIL ovf_sticky got overflow=%b data_out=%0d expected 1 1", overflow, data_out);
        end
    endtask

    task automatic test_rewind();
        logic wf, rf, rdy;
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, wf, rf, rdy);
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, wf, rf, rdy);
        checks++;
        if (data_out !== 8'd3) begin
            errors++;
            $display("FAIL rewind_pre got %0d expected 3", data_out);
        end
        step(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, wf, rf, rdy);
        checks++;
        if (data_out !== 8'd1 || rf !== 1'b0) begin
            errors++;
            $display("FAIL rewind_prio got data_out=%0d rfin=%b expected 1 0", data_out, rf);
        end
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, wf, rf, rdy);
        checks++;
        if (bank_full !== 2'b00 || data_out !== 8'd0) begin
            errors++;
            $display("FAIL rewind_release got bank_full=%b data_out=%0d expected 00 0", bank_full, data_out);
        end
    endtask

    task automatic test_seal_release();
        logic wf, rf, rdy;
        step(1'b1, 8'd20, 1'b0, 1'b0, 1'b0, wf, rf, rdy);
        step(1'b1, 8'd0,  1'b0, 1'b0, 1'b0, wf, rf, rdy);
        step(1'b1, 8'd30, 1'b0, 1'b0, 1'b0, wf, rf, rdy);
        checks++;
        if (bank_full !== 2'b10 || data_out !== 8'd20) begin
            errors++;
            $display("FAIL sr_pre got bank_full=%b data_out=%0d expected 10 20", bank_full, data_out);
        end
        step(1'b1, 8'd0, 1'b0, 1'b0, 1'b1, wf, rf, rdy);
        checks++;
        if (wf !== 1'b1 || bank_full !== 2'b01 || data_out !== 8'd30) begin
            errors++;
            $display("FAIL sr_both got wfin=%b bank_full=%b data_out=%0d expected 1 01 30",
                     wf, bank_full, data_out);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic wf, rf, rdy;
        step(1'b1, 8'd6, 1'b0, 1'b0, 1'b0, wf, rf, rdy);
        step(1'b1, 8'd8, 1'b0, 1'b0, 1'b0, wf, rf, rdy);
        do_reset();
        checks++;
        if (bank_full !== 2'b00 || data_out_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rmf_reset got bank_full=%b vld=%b overflow=%b expected 00 0 0",
                     bank_full, data_out_valid, overflow);
        end
        step(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, wf, rf, rdy);
        step(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, wf, rf, rdy);
        checks++;
        if (data_out !== 8'd2 || bank_full !== 2'b01) begin
            errors++;
            $display("FAIL rmf_refill got data_out=%0d bank_full=%b expected 2 01", data_out, bank_full);
        end
    endtask

    initial begin
        reset         = 1'b1;
        data_in_valid = 1'b0;
        data_in       = 8'd0;
        write_en      = 1'b0;
        index_inc     = 1'b0;
        rewind        = 1'b0;
        bank_release  = 1'b0;
        test_reset();
        test_basic();
        test_ping_pong();
        test_overflow();
        test_rewind();
        test_seal_release();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
